fifoc2cmd: RTL and testbench

- Downstream consumer of command FIFO C. Pops the bytes of one received UDP command payload, assembles 3-byte records {addr, data_hi, data_lo} and issues register-write strobes to the device control bus.
- Runs one packet per fs/fd handshake, using the same level handshake as the MAC-side stages.
- Packet length arrives on dev_rx_len (UDP length minus 8).

---
 rtl/fifoc2cmd.sv | 131 +++++++++++++
 tb/tb_fifoc2cmd.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifoc2cmd.sv
// Command FIFO C consumer: pops one UDP command payload per fs/fd handshake,
// assembles {addr, data_hi, data_lo} records and issues register-write strobes.
module fifoc2cmd #(
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [11:0] dev_rx_len,
  input  logic [7:0]  fifoc_rxd,
  output logic        fifoc_rxen,
  input  logic        fifoc_empty,
  output logic        cmd_wen,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic [10:0] cmd_cnt,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {IDLE, WORK, LAST} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [11:0]     len;
  logic [11:0]     rd_cnt;
  logic [11:0]     rx_cnt;
  logic [1:0]      byte_pos;
  logic [TO_W-1:0] to_cnt;
  logic            rx_vld;
  logic [7:0]      addr_r;
  logic [7:0]      hi_r;
  logic            pending;

  assign pending = (rd_cnt < len);

  // The pop strobe is combinational so a byte can be popped every cycle;
  // the FIFO answers with data one cycle later (tracked by rx_vld).
  assign fifoc_rxen = (state == WORK) && pending && !fifoc_empty;

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values; blocking here would make the exit test see updated counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      fd       <= 1'b0;
      len      <= '0;
      rd_cnt   <= '0;
      rx_cnt   <= '0;
      byte_pos <= '0;
      to_cnt   <= '0;
      rx_vld   <= 1'b0;
      addr_r   <= '0;
      hi_r     <= '0;
      cmd_wen  <= 1'b0;
      cmd_addr <= '0;
      cmd_data <= '0;
      cmd_cnt  <= '0;
      err      <= '0;
    end else begin
      cmd_wen <= 1'b0;
      rx_vld  <= fifoc_rxen;
      case (state)
        IDLE: begin
          if (fs) begin
            len      <= dev_rx_len;
            rd_cnt   <= '0;
            rx_cnt   <= '0;
            byte_pos <= '0;
            to_cnt   <= '0;
            cmd_cnt  <= '0;
            err      <= '0;
            state    <= WORK;
          end
        end
        WORK: begin
          if (fifoc_rxen) begin
            rd_cnt <= rd_cnt + 12'd1;
            to_cnt <= '0;
          end else if (pending) begin
            to_cnt <= to_cnt + 1'b1;
          end
          if (rx_vld) begin
            rx_cnt <= rx_cnt + 12'd1;
            case (byte_pos)
              2'd0: begin
                addr_r   <= fifoc_rxd;
                byte_pos <= 2'd1;
              end
              2'd1: begin
                hi_r     <= fifoc_rxd;
                byte_pos <= 2'd2;
              end
              default: begin
                cmd_wen  <= 1'b1;
                cmd_addr <= addr_r;
                cmd_data <= {hi_r, fifoc_rxd};
                cmd_cnt  <= cmd_cnt + 11'd1;
                byte_pos <= 2'd0;
              end
            endcase
          end
          // All bytes in: byte_pos now equals len mod 3, so a nonzero value
          // means a trailing fragment was dropped.
          if (rx_cnt == len && !rx_vld) begin
            err[0] <= (byte_pos != 2'd0);
            fd     <= 1'b1;
            state  <= LAST;
          end else if (pending && fifoc_empty && to_cnt == TO_LAST) begin
            err[1] <= 1'b1;
            fd     <= 1'b1;
            state  <= LAST;
          end
        end
        LAST: begin
          if (!fs) begin
            fd    <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          fd    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifoc2cmd.sv
// Self-checking bench for fifoc2cmd: a FIFO model feeds bytes, a scoreboard
// queue holds expected register writes and is drained by a strobe monitor.
module tb_fifoc2cmd;

  localparam int TO   = 64;
  localparam int TO_W = 7;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [10:0] cnt;
  } rec_t;

  logic        clk;
  logic        rst;
  logic        fs;
  logic        fd;
  logic [11:0] dev_rx_len;
  logic [7:0]  fifoc_rxd;
  logic        fifoc_rxen;
  logic        fifoc_empty;
  logic        cmd_wen;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [10:0] cmd_cnt;
  logic [1:0]  err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:63];
  int wr_ptr  = 0;
  int rd_ptr  = 0;
  int pop_cnt = 0;
  rec_t exp_q[$];

  fifoc2cmd #(.TIMEOUT(TO), .TO_W(TO_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fs         (fs),
    .fd         (fd),
    .dev_rx_len (dev_rx_len),
    .fifoc_rxd  (fifoc_rxd),
    .fifoc_rxen (fifoc_rxen),
    .fifoc_empty(fifoc_empty),
    .cmd_wen    (cmd_wen),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_cnt    (cmd_cnt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: pointers advance with non-blocking updates so the DUT sees
  // the pre-edge empty flag in the same cycle it pops.
  assign fifoc_empty = (rd_ptr == wr_ptr);
  initial fifoc_rxd = '0;
  always @(posedge clk) begin
    if (fifoc_rxen) begin
      fifoc_rxd <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
      pop_cnt   <= pop_cnt + 1;
    end
  end

  // Strobe monitor: every cmd_wen must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && cmd_wen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wen: got addr=%h data=%h cnt=%0d, required no strobe",
                 cmd_addr, cmd_data, cmd_cnt);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        if (cmd_addr !== e.addr || cmd_data !== e.data || cmd_cnt !== e.cnt) begin
          failures++;
          $display("FAIL wen_record: got addr=%h data=%h cnt=%0d, required addr=%h data=%h cnt=%0d",
                   cmd_addr, cmd_data, cmd_cnt, e.addr, e.data, e.cnt);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_rec(input logic [7:0] a, input logic [15:0] d, input logic [10:0] c);
    rec_t e;
    e.addr = a; e.data = d; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic start_packet(input logic [11:0] len);
    @(negedge clk);
    dev_rx_len = len;
    fs = 1'b1;
  endtask

  task automatic wait_fd(input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (fd === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; fs = 1'b0; dev_rx_len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fd, cmd_wen, fifoc_rxen, err, cmd_cnt, cmd_addr, cmd_data} !== '0) begin
      failures++;
      $display("FAIL reset_state: got fd=%b wen=%b rxen=%b err=%b cnt=%0d addr=%h data=%h, required all 0",
               fd, cmd_wen, fifoc_rxen, err, cmd_cnt, cmd_addr, cmd_data);
    end
    rst = 1'b1;
  endtask

  task automatic test_two_records();
    int n; bit ok; int p0;
    p0 = pop_cnt;
    expect_rec(8'h01, 16'h1234, 11'd1);
    expect_rec(8'h02, 16'hABCD, 11'd2);
    foreach (mem[i]) if (i < 0) mem[i] = '0;
    push_byte(8'h01); push_byte(8'h12); push_byte(8'h34);
    push_byte(8'h02); push_byte(8'hAB); push_byte(8'hCD);
    start_packet(12'd6);
    wait_fd(40, n, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL two_fd: fd never rose in 40 cycles, required fd=1"); end
    checks++;
    if (cmd_cnt !== 11'd2 || err !== 2'b00) begin
      failures++;
      $display("FAIL two_status: got cnt=%0d err=%b, required cnt=2 err=00", cmd_cnt, err);
    end
    checks++;
    if (pop_cnt - p0 != 6) begin
      failures++;
      $display("FAIL two_pops: got %0d pops, required 6", pop_cnt - p0);
    end
    checks++;
    if (cmd_addr !== 8'h02 || cmd_data !== 16'hABCD) begin
      failures++;
      $display("FAIL two_hold: got addr=%h data=%h, required addr=02 data=abcd", cmd_addr, cmd_data);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL two_missing: %0d strobes not seen, required 0", exp_q.size());
    end
    fs = 1'b0;
    @(negedge clk);
    checks++;
    if (fd !== 1'b0) begin failures++; $display("FAIL two_fd_low: got fd=%b, required 0", fd); end
  endtask

  task automatic test_empty_packet();
    int n; bit ok; int p0;
    p0 = pop_cnt;
    start_packet(12'd0);
    wait_fd(10, n, ok);
    checks++;
    if (!ok || n != 2) begin
      failures++;
      $display("FAIL empty_latency: got ok=%b cycles=%0d, required fd after 2 cycles", ok, n);
    end
    checks++;
    if (pop_cnt != p0 || err !== 2'b00 || cmd_cnt !== 11'd0) begin
      failures++;
      $display("FAIL empty_status: got pops=%0d err=%b cnt=%0d, required pops=0 err=00 cnt=0",
               pop_cnt - p0, err, cmd_cnt);
    end
    fs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    int n; bit ok; int p0;
    p0 = pop_cnt;
    expect_rec(8'h10, 16'h00FF, 11'd1);
    push_byte(8'h10); push_byte(8'h00); push_byte(8'hFF);
    push_byte(8'h20); push_byte(8'h01);
    start_packet(12'd5);
    wait_fd(40, n, ok);
    checks++;
    if (!ok || err !== 2'b01 || cmd_cnt !== 11'd1) begin
      failures++;
      $display("FAIL mis_status: got ok=%b err=%b cnt=%0d, required ok=1 err=01 cnt=1", ok, err, cmd_cnt);
    end
    checks++;
    if (pop_cnt - p0 != 5 || fifoc_empty !== 1'b1) begin
      failures++;
      $display("FAIL mis_pops: got pops=%0d empty=%b, required pops=5 empty=1", pop_cnt - p0, fifoc_empty);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL mis_missing: %0d strobes not seen, required 0", exp_q.size());
    end
    fs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    int n; bit ok; int p0; bit early;
    p0 = pop_cnt;
    expect_rec(8'h50, 16'h5152, 11'd1);
    push_byte(8'h50);
    start_packet(12'd3);
    early = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (fd === 1'b1) early = 1'b1;
    end
    checks++;
    if (early || pop_cnt - p0 != 1) begin
      failures++;
      $display("FAIL stall_wait: got early_fd=%b pops=%0d, required early_fd=0 pops=1", early, pop_cnt - p0);
    end
    push_byte(8'h51); push_byte(8'h52);
    wait_fd(20, n, ok);
    checks++;
    if (!ok || err !== 2'b00 || cmd_cnt !== 11'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_done: got ok=%b err=%b cnt=%0d pending=%0d, required ok=1 err=00 cnt=1 pending=0",
               ok, err, cmd_cnt, exp_q.size());
    end
    fs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n; bit ok; int p0;
    p0 = pop_cnt;
    push_byte(8'h77);
    start_packet(12'd3);
    wait_fd(TO + 20, n, ok);
    // One cycle to enter WORK, one pop, then TO consecutive empty cycles.
    checks++;
    if (!ok || n != TO + 2) begin
      failures++;
      $display("FAIL to_latency: got ok=%b cycles=%0d, required fd after %0d cycles", ok, n, TO + 2);
    end
    checks++;
    if (err !== 2'b10 || cmd_cnt !== 11'd0 || pop_cnt - p0 != 1) begin
      failures++;
      $display("FAIL to_status: got err=%b cnt=%0d pops=%0d, required err=10 cnt=0 pops=1",
               err, cmd_cnt, pop_cnt - p0);
    end
    fs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_and_hold();
    int n; bit ok; int p0; int waited; bit bad;
    p0 = pop_cnt;
    push_byte(8'hAA); push_byte(8'hBB);
    start_packet(12'd3);
    waited = 0;
    while (pop_cnt - p0 < 2 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (pop_cnt - p0 != 2) begin
      failures++;
      $display("FAIL mid_pops: got %0d pops, required 2", pop_cnt - p0);
    end
    rst = 1'b0;
    fs  = 1'b0;
    @(negedge clk);
    checks++;
    if ({fd, cmd_wen, fifoc_rxen, err, cmd_cnt, cmd_addr, cmd_data} !== '0) begin
      failures++;
      $display("FAIL mid_reset: got fd=%b wen=%b rxen=%b err=%b cnt=%0d addr=%h data=%h, required all 0",
               fd, cmd_wen, fifoc_rxen, err, cmd_cnt, cmd_addr, cmd_data);
    end
    rst = 1'b1;
    p0 = pop_cnt;
    expect_rec(8'h33, 16'h4455, 11'd1);
    push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
    start_packet(12'd3);
    wait_fd(30, n, ok);
    checks++;
    if (!ok || err !== 2'b00 || cmd_cnt !== 11'd1 || pop_cnt - p0 != 3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL fresh_pkt: got ok=%b err=%b cnt=%0d pops=%0d pending=%0d, required 1 00 1 3 0",
               ok, err, cmd_cnt, pop_cnt - p0, exp_q.size());
    end
    // fs stays high: LAST must hold and ignore a newly arrived byte.
    push_byte(8'h99);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (fd !== 1'b1 || fifoc_rxen !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || pop_cnt - p0 != 3) begin
      failures++;
      $display("FAIL hold_last: got left_last=%b pops=%0d, required left_last=0 pops=3", bad, pop_cnt - p0);
    end
    fs = 1'b0;
    @(negedge clk);
    checks++;
    if (fd !== 1'b0) begin failures++; $display("FAIL hold_release: got fd=%b, required 0", fd); end
  endtask

  initial begin
    test_reset();
    test_two_records();
    test_empty_packet();
    test_misaligned();
    test_stall();
    test_timeout();
    test_reset_mid_and_hold();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
